count_tracker: RTL and testbench
================================

# count_tracker

Observer stage that sits directly downstream of the 4-bit up/down counter and consumes its `count` and `RCO` outputs. It samples `count` every cycle and classifies each step as up, down, hold or illegal jump. It tracks the running direction with a small FSM, turns `RCO` into a one-cycle wrap event, counts wraps, and measures the period between wraps. It feeds status and display logic that must not re-derive direction from the raw count.

## Interface
- `W`, 4: counter width; wrap modulus is 2^W.
- `PW`, 8: width of the wrap counter and the period counter.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low (`reset==0` clears all state).
- `count` in W: counter value, synchronous to `clk`.
- `rco` in 1: counter ripple-carry output, high when `count==0`.
- `dir` out 1: tracked direction; 0 = up, 1 = down.
- `dir_valid` out 1: high in TRACK_UP or TRACK_DN.
- `err` out 1: high for one cycle after an illegal jump is sampled.
- `err_sticky` out 1: set on any illegal jump; cleared only by reset.
- `wrap_pulse` out 1: one-cycle pulse per wrap event.
- `wrap_cnt` out PW: number of wraps, saturating at 2^PW-1.
- `period` out PW: cycles between the last two wraps, saturating.
- `period_valid` out 1: set once two wraps have been seen; cleared by reset.

## Operation
- Step classification: `delta = (count - prev_count) mod 2^W`.
  - UP when `delta==1`; this includes 15→0.
  - DN when `delta==2^W-1`; this includes 0→15.
  - HOLD when `delta==0`.
  - JUMP for any other value.
- FSM states and transitions:
  - INIT: captures `prev_count` on the first edge after reset release, then moves to PRIME.
  - PRIME: UP→TRACK_UP; DN→TRACK_DN; HOLD→PRIME; JUMP→ERR.
  - TRACK_UP: UP or HOLD stays; DN→TRACK_DN; JUMP→ERR.
  - TRACK_DN: mirror of TRACK_UP.
  - ERR: UP→TRACK_UP; DN→TRACK_DN; HOLD or JUMP stays in ERR.
- `prev_count` updates every cycle in every state after INIT.
- `dir` follows the last UP/DN step. It holds its value through HOLD and ERR.
- Wrap detection:
  - `wrap_pulse` fires on a rising edge of `rco` (`rco & ~rco_d`), only while in TRACK_UP or TRACK_DN.
  - A counter parked at 0 produces exactly one pulse.
  - An `rco` edge sampled in INIT, PRIME or ERR is ignored.
- Wrap count: `wrap_cnt` increments on each `wrap_pulse` and saturates; it never wraps.
- Period:
  - Cycle counter starts at the first `wrap_pulse` and saturates at 2^PW-1.
  - On each later `wrap_pulse`, `period` takes the cycle count between the two pulses, `period_valid` sets, and the counter restarts.
  - A free-running counter (either direction) gives `period==16`.
  - Entering ERR stops period measurement; `period`, `period_valid` and `wrap_cnt` keep their values.
  - The next wrap after recovery restarts measurement as a "first" wrap.
- Simultaneous events in one cycle: JUMP into ERR takes priority over an `rco` edge, so no pulse is issued.

## Timing
- All outputs are registered. Reset value of every output is 0, and the FSM resets to INIT.
- Latency:
  - `count` changing at edge k is classified at edge k+1.
  - `dir`, `dir_valid` and `err` reflect that classification after edge k+1.
  - `wrap_pulse` is high for the cycle after edge k+1, where edge k drove `rco` high.
- Reset asserted mid-operation clears everything immediately, without waiting for a clock edge. After release, one INIT cycle and one PRIME step must occur before `dir_valid` can rise.

## Structure
- Shared include `counter_defs.vh`:
  - FSM state encodings: INIT, PRIME, TRACK_UP, TRACK_DN, ERR.
  - Step codes: UP, DN, HOLD, JUMP.
  - Default widths W=4 and PW=8.
- Sub-module `rise_detect`: 1-bit registered rising-edge detector with async active-low reset. Used for `rco`.
- The sat-counter, FSM and classifier stay in `count_tracker`.

## Test plan
- Reset release, then count 0,1,2,…,15,0,1,… → TRACK_UP after 2 edges, `dir=0`; `wrap_pulse` every 16 cycles; `period=16` and `period_valid=1` after the 2nd wrap.
- Count 3,2,1,0,15,… → TRACK_DN, `dir=1`; `wrap_pulse` at each 0; `period=16`.
- Count up to 5, hold 5 for 4 cycles, step to 4 → `dir` stays 0 during the hold, then `dir=1` one edge after 4 is applied; `err` stays 0.
- Count 7 then 12 → `err` pulses 1 cycle, `err_sticky=1`, `dir_valid=0`; step to 13 → TRACK_UP, `err_sticky` still 1.
- Count held at 0 (`rco=1`) for 10 cycles → exactly one `wrap_pulse`; `wrap_cnt` increments by 1.
- Drive reset low mid-count while `wrap_cnt=3` → all outputs read 0 before the next clock edge; state is INIT after release.

Source files
------------

// File: rtl/count_tracker_pkg.sv
// Shared encodings and default widths for the count_tracker observer.
package count_tracker_pkg;

    localparam int W_DEF  = 4;
    localparam int PW_DEF = 8;

    typedef enum logic [2:0] {
        S_INIT,
        S_PRIME,
        S_TRACK_UP,
        S_TRACK_DN,
        S_ERR
    } state_t;

    typedef enum logic [1:0] {
        STEP_UP,
        STEP_DN,
        STEP_HOLD,
        STEP_JUMP
    } step_t;

    function automatic logic is_track(input state_t s);
        return (s == S_TRACK_UP) || (s == S_TRACK_DN);
    endfunction

endpackage

// File: rtl/count_tracker_rise_detect.sv
// Rising-edge detector: registers the input and flags a 0->1 transition.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic d_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/count_tracker.sv
// Observes an up/down counter: classifies each step, tracks direction,
// turns rco into wrap events, counts wraps and measures the wrap period.
module count_tracker
    import count_tracker_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int PW = PW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [W-1:0]  count,
    input  logic          rco,
    output logic          dir,
    output logic          dir_valid,
    output logic          err,
    output logic          err_sticky,
    output logic          wrap_pulse,
    output logic [PW-1:0] wrap_cnt,
    output logic [PW-1:0] period,
    output logic          period_valid
);

    state_t        state;
    step_t         step;
    logic [W-1:0]  prev_count;
    logic [W-1:0]  delta;
    logic [PW-1:0] cyc_cnt;
    logic          measuring;
    logic          rco_rise;
    logic          jump;
    logic          wrap_event;

    rise_detect u_rco_rise (
        .clk   (clk),
        .reset (reset),
        .d     (rco),
        .rise  (rco_rise)
    );

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        step  = STEP_JUMP;
        delta = count - prev_count;
        if (delta == W'(1)) begin
            step = STEP_UP;
        end else if (delta == {W{1'b1}}) begin
            step = STEP_DN;
        end else if (delta == '0) begin
            step = STEP_HOLD;
        end
    end

    // A jump outranks a simultaneous rco edge: it leaves tracking, so no wrap.
    assign jump       = (state != S_INIT) && (step == STEP_JUMP);
    assign wrap_event = rco_rise && is_track(state) && !jump;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_INIT;
            prev_count   <= '0;
            dir          <= 1'b0;
            dir_valid    <= 1'b0;
            err          <= 1'b0;
            err_sticky   <= 1'b0;
            wrap_pulse   <= 1'b0;
            wrap_cnt     <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            cyc_cnt      <= '0;
            measuring    <= 1'b0;
        end else begin
            prev_count <= count;
            wrap_pulse <= wrap_event;
            err        <= jump;
            if (jump) begin
                err_sticky <= 1'b1;
            end

            // Outside INIT the next state depends only on the step: UP/DN pick a
            // tracking state, JUMP lands in ERR, HOLD keeps the current state.
            if (state == S_INIT) begin
                state <= S_PRIME;
            end else begin
                unique case (step)
                    STEP_UP: begin
                        state     <= S_TRACK_UP;
                        dir       <= 1'b0;
                        dir_valid <= 1'b1;
                    end
                    STEP_DN: begin
                        state     <= S_TRACK_DN;
                        dir       <= 1'b1;
                        dir_valid <= 1'b1;
                    end
                    STEP_HOLD: begin
                    end
                    STEP_JUMP: begin
                        state     <= S_ERR;
                        dir_valid <= 1'b0;
                    end
                endcase
            end

            // Period runs from one wrap to the next; an error drops the reference wrap.
            if (jump) begin
                measuring <= 1'b0;
            end else if (wrap_event) begin
                if (wrap_cnt != {PW{1'b1}}) begin
                    wrap_cnt <= wrap_cnt + 1'b1;
                end
                if (measuring) begin
                    period       <= cyc_cnt;
                    period_valid <= 1'b1;
                end
                measuring <= 1'b1;
                cyc_cnt   <= PW'(1);
            end else if (measuring && (cyc_cnt != {PW{1'b1}})) begin
                cyc_cnt <= cyc_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_count_tracker.sv
// Scoreboard bench for count_tracker: directed count sequences, expected wrap/err events queued.
module tb_count_tracker;
    import count_tracker_pkg::*;

    localparam int W  = 4;
    localparam int PW = 8;

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic [W-1:0]  count = '0;
    logic          rco   = 1'b1;
    logic          dir, dir_valid, err, err_sticky, wrap_pulse, period_valid;
    logic [PW-1:0] wrap_cnt, period;

    typedef struct {
        logic       is_wrap;
        logic       dir;
        logic       dir_valid;
        logic       err_sticky;
        logic [7:0] wrap_cnt;
        logic [7:0] period;
        logic       period_valid;
    } evt_t;

    evt_t sb[$];
    evt_t mon_e;
    int   checks = 0;
    int   errors = 0;

    count_tracker #(.W(W), .PW(PW)) dut (
        .clk          (clk),
        .reset        (reset),
        .count        (count),
        .rco          (rco),
        .dir          (dir),
        .dir_valid    (dir_valid),
        .err          (err),
        .err_sticky   (err_sticky),
        .wrap_pulse   (wrap_pulse),
        .wrap_cnt     (wrap_cnt),
        .period       (period),
        .period_valid (period_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Present a count value and let the DUT sample it on the next rising edge.
    task automatic drive(input int v);
        count = v[W-1:0];
        rco   = (v == 0);
        @(posedge clk);
        #1;
    endtask

    task automatic walk(input int first, input int last);
        if (first <= last) begin
            for (int v = first; v <= last; v++) drive(v);
        end else begin
            for (int v = first; v >= last; v--) drive(v);
        end
    endtask

    task automatic expect_evt(input logic w, input logic d, input logic dv, input logic es,
                              input int cnt, input int per, input logic pv);
        evt_t e;
        e.is_wrap      = w;
        e.dir          = d;
        e.dir_valid    = dv;
        e.err_sticky   = es;
        e.wrap_cnt     = cnt[7:0];
        e.period       = per[7:0];
        e.period_valid = pv;
        sb.push_back(e);
    endtask

    // Monitor: every wrap or err pulse must match the oldest queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (wrap_pulse === 1'b1 || err === 1'b1) begin
                if (sb.size() == 0) begin
                    check("spurious_event", 32'({wrap_pulse, err}), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("evt_wrap_pulse", 32'(wrap_pulse), 32'(mon_e.is_wrap));
                    check("evt_err", 32'(err), 32'(!mon_e.is_wrap));
                    check("evt_dir", 32'(dir), 32'(mon_e.dir));
                    check("evt_dir_valid", 32'(dir_valid), 32'(mon_e.dir_valid));
                    check("evt_err_sticky", 32'(err_sticky), 32'(mon_e.err_sticky));
                    check("evt_wrap_cnt", 32'(wrap_cnt), 32'(mon_e.wrap_cnt));
                    check("evt_period", 32'(period), 32'(mon_e.period));
                    check("evt_period_valid", 32'(period_valid), 32'(mon_e.period_valid));
                end
            end
        end
    end

    initial begin
        #12;
        check("reset_outputs", 32'({dir, dir_valid, err, err_sticky, wrap_pulse,
                                    wrap_cnt, period, period_valid}), 32'd0);
        reset = 1'b1;

        // Free-running up count from 0
        drive(0);
        check("prime_dir_valid", 32'(dir_valid), 32'd0);
        drive(1);
        check("up_dir_valid", 32'(dir_valid), 32'd1);
        check("up_dir", 32'(dir), 32'd0);
        walk(2, 15);
        expect_evt(1'b1, 1'b0, 1'b1, 1'b0, 1, 0, 1'b0);
        drive(0);
        walk(1, 15);
        expect_evt(1'b1, 1'b0, 1'b1, 1'b0, 2, 16, 1'b1);
        drive(0);
        walk(1, 15);
        expect_evt(1'b1, 1'b0, 1'b1, 1'b0, 3, 16, 1'b1);
        drive(0);
        walk(1, 5);
        check("pre_reset_wrap_cnt", 32'(wrap_cnt), 32'd3);

        // Asynchronous reset mid-count
        reset = 1'b0;
        #1;
        check("async_reset_outputs", 32'({dir, dir_valid, err, err_sticky, wrap_pulse,
                                          wrap_cnt, period, period_valid}), 32'd0);
        check("async_reset_state", 32'(dut.state), 32'(S_INIT));
        #3;
        reset = 1'b1;
        #1;
        check("post_release_state", 32'(dut.state), 32'(S_INIT));

        // Down count 3,2,1,0,15,...
        drive(3);
        check("dn_prime_dir_valid", 32'(dir_valid), 32'd0);
        drive(2);
        check("dn_dir_valid", 32'(dir_valid), 32'd1);
        check("dn_dir", 32'(dir), 32'd1);
        drive(1);
        expect_evt(1'b1, 1'b1, 1'b1, 1'b0, 1, 0, 1'b0);
        drive(0);
        walk(15, 1);
        expect_evt(1'b1, 1'b1, 1'b1, 1'b0, 2, 16, 1'b1);
        drive(0);

        // Up to 5, hold 5 for four cycles, step to 4
        drive(1);
        check("turn_up_dir", 32'(dir), 32'd0);
        walk(2, 5);
        for (int i = 0; i < 4; i++) begin
            drive(5);
            check("hold_dir", 32'(dir), 32'd0);
            check("hold_dir_valid", 32'(dir_valid), 32'd1);
        end
        drive(4);
        check("turn_dn_dir", 32'(dir), 32'd1);
        check("turn_dn_err", 32'(err), 32'd0);

        // Illegal jump 7 -> 12, then recover with 13
        walk(5, 7);
        expect_evt(1'b0, 1'b0, 1'b0, 1'b1, 2, 16, 1'b1);
        drive(12);
        check("jump_err", 32'(err), 32'd1);
        check("jump_err_sticky", 32'(err_sticky), 32'd1);
        check("jump_dir_valid", 32'(dir_valid), 32'd0);
        drive(13);
        check("recover_dir_valid", 32'(dir_valid), 32'd1);
        check("recover_err", 32'(err), 32'd0);
        check("recover_err_sticky", 32'(err_sticky), 32'd1);

        // First wrap after recovery keeps the old period; then park at 0 for 10 cycles
        walk(14, 15);
        expect_evt(1'b1, 1'b0, 1'b1, 1'b1, 3, 16, 1'b1);
        drive(0);
        repeat (9) drive(0);
        check("parked_wrap_cnt", 32'(wrap_cnt), 32'd3);
        walk(1, 15);
        expect_evt(1'b1, 1'b0, 1'b1, 1'b1, 4, 25, 1'b1);
        drive(0);

        // Jump onto 0 (rco edge in the same cycle) gives err, not a wrap
        walk(1, 7);
        expect_evt(1'b0, 1'b0, 1'b0, 1'b1, 4, 25, 1'b1);
        drive(0);
        drive(1);
        check("recover2_dir_valid", 32'(dir_valid), 32'd1);
        walk(2, 15);
        expect_evt(1'b1, 1'b0, 1'b1, 1'b1, 5, 25, 1'b1);
        drive(0);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
